// File: rtl/g15_timing_pkg.sv
// Shared drum timing constants and controller state encoding.
package g15_timing_pkg;

  localparam int BITS_PER_WORD  = 29;
  localparam int WORDS_PER_LINE = 108;
  localparam int LINE_BITS      = BITS_PER_WORD * WORDS_PER_LINE;

  localparam logic [4:0] LAST_BIT  = 5'(BITS_PER_WORD - 1);
  localparam logic [6:0] LAST_WORD = 7'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER
  } xfer_state_t;

  // True when a word number addresses an existing word on a line.
  function automatic logic legal_word(input logic [6:0] w);
    return w <= LAST_WORD;
  endfunction

endpackage

// File: rtl/word_timer.sv
// Drum position counter: bit time within a word, word within a line,
// plus registered bit-0 / bit-28 strobes aligned with the counters.
module word_timer
  import g15_timing_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [4:0] bit_t,
  output logic [6:0] word_t,
  output logic       t0,
  output logic       t28,
  output logic       bit_last,   // current cycle is the last bit of the word
  output logic [6:0] word_inc    // word number that follows the current one
);

  logic [4:0] bit_reg, bit_next;
  logic [6:0] word_reg, word_next;
  logic       t0_reg, t28_reg;

  // Next position; the strobes are derived from the next bit so they
  // line up with the registered counter.
  always_comb begin
    bit_last  = (bit_reg == LAST_BIT);
    word_inc  = (word_reg == LAST_WORD) ? 7'd0 : word_reg + 7'd1;
    bit_next  = bit_last ? 5'd0 : bit_reg + 5'd1;
    word_next = bit_last ? word_inc : word_reg;
  end

  // Position and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_reg  <= 5'd0;
      word_reg <= 7'd0;
      t0_reg   <= 1'b1;
      t28_reg  <= 1'b0;
    end else begin
      bit_reg  <= bit_next;
      word_reg <= word_next;
      t0_reg   <= (bit_next == 5'd0);
      t28_reg  <= (bit_next == LAST_BIT);
    end
  end

  assign bit_t  = bit_reg;
  assign word_t = word_reg;
  assign t0     = t0_reg;
  assign t28    = t28_reg;

endmodule

// File: rtl/transfer_ctl.sv
// Drum line transfer controller: latches a command, waits for the start
// word to come under the heads, gates TR through the last word, and drives
// one-hot source/destination selects while busy.
module transfer_ctl
  import g15_timing_pkg::*;
(
  input  logic       CLOCK,
  input  logic       rst_n,
  input  logic       CMD_LOAD,
  input  logic [4:0] CMD_S,
  input  logic [4:0] CMD_D,
  input  logic [6:0] CMD_L,
  input  logic [6:0] CMD_T,
  input  logic       CMD_IMM,
  input  logic       HALT,
  output logic [7:0] DG,
  output logic [7:0] SG,
  output logic       DU,
  output logic       DV,
  output logic       DW,
  output logic       DX,
  output logic       SU,
  output logic       SV,
  output logic       SW,
  output logic       SX,
  output logic       TR,
  output logic [4:0] BIT_T,
  output logic [6:0] WORD_T,
  output logic       T0,
  output logic       T28,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  logic       bit_last;
  logic [6:0] word_inc;

  word_timer u_timer (
    .clk      (CLOCK),
    .rst_n    (rst_n),
    .bit_t    (BIT_T),
    .word_t   (WORD_T),
    .t0       (T0),
    .t28      (T28),
    .bit_last (bit_last),
    .word_inc (word_inc)
  );

  xfer_state_t state_reg, state_next;
  logic [4:0]  s_reg, s_next, d_reg, d_next;
  logic [6:0]  t_reg, t_next, start_reg, start_next;
  logic        tr_next, done_next, err_next, busy_next;
  logic        tr_reg, done_reg, err_reg, busy_reg;
  logic [7:0]  dg_reg, sg_reg, dg_dec, sg_dec;
  logic [3:0]  dl_reg, sl_reg, dl_dec, sl_dec;
  logic [6:0]  start_word;
  logic        bad_cmd;

  assign start_word = CMD_IMM ? word_inc : CMD_L;
  assign bad_cmd    = (!CMD_IMM && !legal_word(CMD_L)) || !legal_word(CMD_T);

  // One-hot decodes of the addresses that will be held next cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_group
      assign dg_dec[gi] = (d_next[4:2] == 3'(gi));
      assign sg_dec[gi] = (s_next[4:2] == 3'(gi));
    end
    for (gi = 0; gi < 4; gi++) begin : g_low
      assign dl_dec[gi] = (d_next[1:0] == 2'(gi));
      assign sl_dec[gi] = (s_next[1:0] == 2'(gi));
    end
  endgenerate

  // Next-state and next-output logic; TR is raised on the edge that brings
  // bit 0 of the start word, and dropped after bit 28 of the last word.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    d_next     = d_reg;
    t_next     = t_reg;
    start_next = start_reg;
    tr_next    = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (CMD_LOAD && !HALT) begin
          if (bad_cmd) begin
            err_next = 1'b1;
          end else begin
            s_next     = CMD_S;
            d_next     = CMD_D;
            t_next     = CMD_T;
            start_next = start_word;
            if (bit_last && word_inc == start_word) begin
              state_next = XFER;
              tr_next    = 1'b1;
            end else begin
              state_next = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (HALT) begin
          state_next = IDLE;
        end else if (bit_last && word_inc == start_reg) begin
          state_next = XFER;
          tr_next    = 1'b1;
        end
      end
      XFER: begin
        if (HALT) begin
          state_next = IDLE;
        end else if (bit_last && WORD_T == t_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          tr_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  // State, latched command and registered outputs.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      s_reg     <= 5'd0;
      d_reg     <= 5'd0;
      t_reg     <= 7'd0;
      start_reg <= 7'd0;
      tr_reg    <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      dg_reg    <= 8'd0;
      sg_reg    <= 8'd0;
      dl_reg    <= 4'd0;
      sl_reg    <= 4'd0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      d_reg     <= d_next;
      t_reg     <= t_next;
      start_reg <= start_next;
      tr_reg    <= tr_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      busy_reg  <= busy_next;
      dg_reg    <= busy_next ? dg_dec : 8'd0;
      sg_reg    <= busy_next ? sg_dec : 8'd0;
      dl_reg    <= busy_next ? dl_dec : 4'd0;
      sl_reg    <= busy_next ? sl_dec : 4'd0;
    end
  end

  assign DG   = dg_reg;
  assign SG   = sg_reg;
  assign DU   = dl_reg[0];
  assign DV   = dl_reg[1];
  assign DW   = dl_reg[2];
  assign DX   = dl_reg[3];
  assign SU   = sl_reg[0];
  assign SV   = sl_reg[1];
  assign SW   = sl_reg[2];
  assign SX   = sl_reg[3];
  assign TR   = tr_reg;
  assign BUSY = busy_reg;
  assign DONE = done_reg;
  assign ERR  = err_reg;

endmodule

// File: tb/tb_transfer_ctl.sv
// Directed bench for transfer_ctl: timing, immediate/deferred/wrapping
// transfers, same-word wait, abort, error/ignore and asynchronous reset.
module tb_transfer_ctl;

  logic       CLOCK = 1'b0;
  logic       rst_n = 1'b1;
  logic       CMD_LOAD = 1'b0, CMD_IMM = 1'b0, HALT = 1'b0;
  logic [4:0] CMD_S = 5'd0, CMD_D = 5'd0;
  logic [6:0] CMD_L = 7'd0, CMD_T = 7'd0;
  logic [7:0] DG, SG;
  logic       DU, DV, DW, DX, SU, SV, SW, SX, TR, T0, T28, BUSY, DONE, ERR;
  logic [4:0] BIT_T;
  logic [6:0] WORD_T;

  int checks = 0;
  int errors = 0;

  transfer_ctl dut (
    .CLOCK(CLOCK), .rst_n(rst_n), .CMD_LOAD(CMD_LOAD), .CMD_S(CMD_S), .CMD_D(CMD_D),
    .CMD_L(CMD_L), .CMD_T(CMD_T), .CMD_IMM(CMD_IMM), .HALT(HALT),
    .DG(DG), .SG(SG), .DU(DU), .DV(DV), .DW(DW), .DX(DX),
    .SU(SU), .SV(SV), .SW(SW), .SX(SX), .TR(TR), .BIT_T(BIT_T), .WORD_T(WORD_T),
    .T0(T0), .T28(T28), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLOCK = ~CLOCK;

  // Advance to the negedge where the drum sits at (w, b).
  task automatic goto_pos(input int w, input int b);
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLOCK);
      if (WORD_T == 7'(w) && BIT_T == 5'(b)) return;
    end
    checks++; errors++;
    $display("FAIL goto_pos timeout: at %0d/%0d, required %0d/%0d", WORD_T, BIT_T, w, b);
  endtask

  // Issue a command on the current negedge; it is sampled on the next posedge.
  task automatic issue(input logic imm, input int l, input int t, input int s, input int d, input logic halt);
    CMD_LOAD = 1'b1; CMD_IMM = imm; CMD_L = 7'(l); CMD_T = 7'(t);
    CMD_S = 5'(s); CMD_D = 5'(d); HALT = halt;
    @(negedge CLOCK);
    CMD_LOAD = 1'b0; HALT = 1'b0;
  endtask

  // Observe from the current negedge until DONE, recording TR activity.
  task automatic measure(output int cnt, output int first_idx, output int first_w,
                         output int first_b, output int done_w, output int done_b,
                         output logic tr_at_done, output logic busy_at_done);
    cnt = 0; first_idx = -1; first_w = -1; first_b = -1; done_w = -1; done_b = -1;
    tr_at_done = 1'bx; busy_at_done = 1'bx;
    for (int i = 0; i < 4000; i++) begin
      if (TR === 1'b1) begin
        if (cnt == 0) begin first_idx = i; first_w = WORD_T; first_b = BIT_T; end
        cnt++;
      end
      if (DONE === 1'b1) begin
        done_w = WORD_T; done_b = BIT_T; tr_at_done = TR; busy_at_done = BUSY;
        return;
      end
      @(negedge CLOCK);
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({BIT_T, WORD_T} !== 12'd0) begin errors++; $display("FAIL reset_pos got %0d/%0d required 0/0", WORD_T, BIT_T); end
    checks++; if ({T0, T28} !== 2'b10) begin errors++; $display("FAIL reset_strobes got T0=%b T28=%b required 1/0", T0, T28); end
    checks++; if ({TR, BUSY, DONE, ERR, DG, SG, DU, DV, DW, DX, SU, SV, SW, SX} !== 28'd0) begin
      errors++; $display("FAIL reset_outputs got TR=%b BUSY=%b DONE=%b ERR=%b DG=%h SG=%h required all 0", TR, BUSY, DONE, ERR, DG, SG); end
    repeat (3) @(negedge CLOCK);
    rst_n = 1'b1;
    @(negedge CLOCK);
    checks++; if (BIT_T !== 5'd1 || WORD_T !== 7'd0) begin errors++; $display("FAIL first_increment got %0d/%0d required 0/1", WORD_T, BIT_T); end
  endtask

  task automatic test_timer;
    repeat (27) @(negedge CLOCK);
    checks++; if (BIT_T !== 5'd28 || T28 !== 1'b1 || T0 !== 1'b0) begin errors++; $display("FAIL bit28 got bit=%0d T28=%b T0=%b required 28/1/0", BIT_T, T28, T0); end
    @(negedge CLOCK);
    checks++; if (BIT_T !== 5'd0 || WORD_T !== 7'd1 || T0 !== 1'b1 || T28 !== 1'b0) begin
      errors++; $display("FAIL word_wrap got %0d/%0d T0=%b T28=%b required 1/0 1/0", WORD_T, BIT_T, T0, T28); end
    goto_pos(107, 28);
    @(negedge CLOCK);
    checks++; if (WORD_T !== 7'd0 || BIT_T !== 5'd0) begin errors++; $display("FAIL line_wrap got %0d/%0d required 0/0", WORD_T, BIT_T); end
  endtask

  task automatic test_immediate;
    int cnt, fi, fw, fb, dw, db; logic trd, bd;
    goto_pos(10, 5);
    issue(1'b1, 0, 12, 0, 18, 1'b0);
    checks++; if (BUSY !== 1'b1 || DG !== 8'h10 || {DU, DV, DW, DX} !== 4'b0010) begin
      errors++; $display("FAIL imm_decode got BUSY=%b DG=%h UVWX=%b%b%b%b required 1/10/0010", BUSY, DG, DU, DV, DW, DX); end
    measure(cnt, fi, fw, fb, dw, db, trd, bd);
    checks++; if (fw != 11 || fb != 0 || fi != 23) begin errors++; $display("FAIL imm_first got %0d/%0d idx %0d required 11/0 idx 23", fw, fb, fi); end
    checks++; if (cnt != 58) begin errors++; $display("FAIL imm_tr_count got %0d required 58", cnt); end
    checks++; if (dw != 13 || db != 0 || trd !== 1'b0 || bd !== 1'b0) begin
      errors++; $display("FAIL imm_done got %0d/%0d TR=%b BUSY=%b required 13/0 0/0", dw, db, trd, bd); end
    @(negedge CLOCK);
    checks++; if (DONE !== 1'b0 || DG !== 8'h00) begin errors++; $display("FAIL imm_after got DONE=%b DG=%h required 0/00", DONE, DG); end
  endtask

  task automatic test_wrap;
    int cnt, fi, fw, fb, dw, db; logic trd, bd;
    issue(1'b0, 106, 1, 6, 0, 1'b0);
    checks++; if (SG !== 8'h02 || {SU, SV, SW, SX} !== 4'b0010 || TR !== 1'b0) begin
      errors++; $display("FAIL wrap_decode got SG=%h UVWX=%b%b%b%b TR=%b required 02/0010/0", SG, SU, SV, SW, SX, TR); end
    measure(cnt, fi, fw, fb, dw, db, trd, bd);
    checks++; if (fw != 106 || fb != 0) begin errors++; $display("FAIL wrap_first got %0d/%0d required 106/0", fw, fb); end
    checks++; if (cnt != 116) begin errors++; $display("FAIL wrap_tr_count got %0d required 116", cnt); end
    checks++; if (dw != 2 || db != 0 || trd !== 1'b0) begin errors++; $display("FAIL wrap_done got %0d/%0d TR=%b required 2/0 0", dw, db, trd); end
  endtask

  task automatic test_error_ignore;
    int cnt, fi, fw, fb, dw, db; logic trd, bd;
    issue(1'b0, 5, 120, 1, 1, 1'b0);
    checks++; if (ERR !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL err_t got ERR=%b BUSY=%b required 1/0", ERR, BUSY); end
    @(negedge CLOCK);
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL err_pulse got ERR=%b required 0", ERR); end
    issue(1'b0, 108, 5, 1, 1, 1'b0);
    checks++; if (ERR !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL err_l got ERR=%b BUSY=%b required 1/0", ERR, BUSY); end
    issue(1'b0, 30, 31, 1, 1, 1'b1);
    checks++; if (BUSY !== 1'b0 || ERR !== 1'b0 || DG !== 8'h00) begin errors++; $display("FAIL halt_wins got BUSY=%b ERR=%b DG=%h required 0/0/00", BUSY, ERR, DG); end
    goto_pos(20, 0);
    issue(1'b1, 120, 21, 3, 7, 1'b0);
    checks++; if (ERR !== 1'b0 || BUSY !== 1'b1 || DG !== 8'h02 || DX !== 1'b1 || SG !== 8'h01 || SX !== 1'b1) begin
      errors++; $display("FAIL imm_ignores_l got ERR=%b BUSY=%b DG=%h DX=%b SG=%h SX=%b required 0/1/02/1/01/1", ERR, BUSY, DG, DX, SG, SX); end
    issue(1'b1, 0, 100, 31, 30, 1'b0);
    checks++; if (DG !== 8'h02 || DX !== 1'b1 || SG !== 8'h01 || SX !== 1'b1) begin
      errors++; $display("FAIL busy_ignore got DG=%h DX=%b SG=%h SX=%b required 02/1/01/1", DG, DX, SG, SX); end
    measure(cnt, fi, fw, fb, dw, db, trd, bd);
    checks++; if (cnt != 29 || fw != 21 || dw != 22 || db != 0) begin
      errors++; $display("FAIL ignore_t got cnt=%0d first=%0d done=%0d/%0d required 29 21 22/0", cnt, fw, dw, db); end
  endtask

  task automatic test_same_word;
    int cnt, fi, fw, fb, dw, db; logic trd, bd;
    goto_pos(40, 3);
    issue(1'b0, 40, 40, 2, 1, 1'b0);
    checks++; if (BUSY !== 1'b1 || TR !== 1'b0) begin errors++; $display("FAIL same_wait got BUSY=%b TR=%b required 1/0", BUSY, TR); end
    measure(cnt, fi, fw, fb, dw, db, trd, bd);
    checks++; if (fi != 3128 || fw != 40 || fb != 0) begin errors++; $display("FAIL same_first got idx %0d at %0d/%0d required 3128 at 40/0", fi, fw, fb); end
    checks++; if (cnt != 29 || dw != 41 || db != 0) begin errors++; $display("FAIL same_count got cnt=%0d done=%0d/%0d required 29 41/0", cnt, dw, db); end
  endtask

  task automatic test_abort;
    int bad;
    issue(1'b0, 48, 55, 9, 5, 1'b0);
    goto_pos(50, 7);
    checks++; if (TR !== 1'b1) begin errors++; $display("FAIL abort_pre got TR=%b required 1", TR); end
    HALT = 1'b1;
    @(negedge CLOCK);
    HALT = 1'b0;
    checks++; if ({TR, BUSY, DONE, DG, SG, DU, DV, DW, DX, SU, SV, SW, SX} !== 27'd0) begin
      errors++; $display("FAIL abort_outputs got TR=%b BUSY=%b DONE=%b DG=%h SG=%h required all 0", TR, BUSY, DONE, DG, SG); end
    bad = 0;
    repeat (200) begin @(negedge CLOCK); if (DONE !== 1'b0 || TR !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles required 0", bad); end
    issue(1'b1, 0, 60, 0, 0, 1'b0);
    checks++; if (BUSY !== 1'b1 || DG !== 8'h01 || DU !== 1'b1) begin errors++; $display("FAIL abort_reload got BUSY=%b DG=%h DU=%b required 1/01/1", BUSY, DG, DU); end
    HALT = 1'b1;
    @(negedge CLOCK);
    HALT = 1'b0;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL wait_halt got BUSY=%b required 0", BUSY); end
  endtask

  task automatic test_reset_mid_xfer;
    goto_pos(70, 0);
    issue(1'b1, 0, 75, 4, 12, 1'b0);
    goto_pos(72, 10);
    checks++; if (TR !== 1'b1) begin errors++; $display("FAIL rst_pre got TR=%b required 1", TR); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({BIT_T, WORD_T} !== 12'd0 || T0 !== 1'b1 || T28 !== 1'b0) begin
      errors++; $display("FAIL async_rst_pos got %0d/%0d T0=%b T28=%b required 0/0 1/0", WORD_T, BIT_T, T0, T28); end
    checks++; if ({TR, BUSY, DONE, ERR, DG, SG, DU, DV, DW, DX, SU, SV, SW, SX} !== 28'd0) begin
      errors++; $display("FAIL async_rst_out got TR=%b BUSY=%b DONE=%b DG=%h SG=%h required all 0", TR, BUSY, DONE, DG, SG); end
    @(negedge CLOCK);
    rst_n = 1'b1;
    @(negedge CLOCK);
    checks++; if (BIT_T !== 5'd1 || WORD_T !== 7'd0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL rst_release got %0d/%0d DONE=%b BUSY=%b required 0/1 0/0", WORD_T, BIT_T, DONE, BUSY); end
    repeat (28) @(negedge CLOCK);
    checks++; if (WORD_T !== 7'd1 || BIT_T !== 5'd0) begin errors++; $display("FAIL rst_word1 got %0d/%0d required 1/0", WORD_T, BIT_T); end
    repeat (29) @(negedge CLOCK);
    checks++; if (WORD_T !== 7'd2 || BIT_T !== 5'd0) begin errors++; $display("FAIL rst_word2 got %0d/%0d required 2/0", WORD_T, BIT_T); end
  endtask

  initial begin
    test_reset;
    test_timer;
    test_immediate;
    test_wrap;
    test_error_ignore;
    test_same_word;
    test_abort;
    test_reset_mid_xfer;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
